// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath width, select-width helper,
// writeback-select encoding and the skid-buffer occupancy states.
package cpu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  // A 2:1 selector still needs one select bit, so clamp at 1.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry skid buffer: a main output register plus one skid register,
// with in_ready taken straight from a flop so it never depends on out_ready.
module skid_buf2
  import cpu_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             accept, transfer;

  assign accept   = in_valid && in_ready_q;
  assign transfer = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      SKID_EMPTY: begin
        if (accept) begin
          state_d = SKID_ONE;
          main_d  = in_data;
        end
      end
      SKID_ONE: begin
        if (accept && !transfer) begin
          state_d = SKID_FULL;
          skid_d  = in_data;
        end else if (accept && transfer) begin
          main_d = in_data;
        end else if (transfer) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        // in_ready is low here, so only a drain can happen.
        if (transfer) begin
          state_d = SKID_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    in_ready_d  = (state_d != SKID_FULL);
    out_valid_d = (state_d != SKID_EMPTY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SKID_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

endmodule

// File: rtl/sel_mux_pipe.sv
// Registered N:1 select mux with valid/ready handshake; the selected word
// is stored in a 2-entry skid buffer and bad selects raise a sticky flag.
module sel_mux_pipe
  import cpu_pkg::*;
#(
  parameter  int WIDTH = XLEN,
  parameter  int N_IN  = 4,
  localparam int SEL_W = sel_w(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err,
  input  logic                  clr_err
);

  logic [WIDTH-1:0] mux_data;
  logic             sel_ok;
  logic             accept;
  logic             sel_err_q, sel_err_d;

  // Out-of-range selects leave mux_data at zero.
  always_comb begin
    mux_data = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (int'(in_sel) == k) mux_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  assign sel_ok = (int'(in_sel) < N_IN);
  assign accept = in_valid && in_ready;

  always_comb begin
    sel_err_d = (sel_err_q && !clr_err) || (accept && !sel_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sel_err_q <= 1'b0;
    else     sel_err_q <= sel_err_d;
  end

  assign sel_err = sel_err_q;

  skid_buf2 #(.WIDTH(WIDTH)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   (mux_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

endmodule

// File: tb/tb_sel_mux_pipe.sv
// Drives a 4-input and a 3-input sel_mux_pipe with identical stimulus and
// checks both against a queue-based model of the buffered beats.
module tb_sel_mux_pipe;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [4*W-1:0] in_data;
  logic [1:0]   in_sel;
  logic         in_valid, out_ready, clr_err;
  logic         rdy4, ov4, err4, rdy3, ov3, err3;
  logic [W-1:0] od4, od3;

  logic [W-1:0] q4[$];
  logic [W-1:0] q3[$];
  bit           merr4, merr3;
  int           asserts = 0;
  int           fails   = 0;

  always #5 clk = ~clk;

  sel_mux_pipe #(.WIDTH(W), .N_IN(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(rdy4), .out_data(od4), .out_valid(ov4),
    .out_ready(out_ready), .sel_err(err4), .clr_err(clr_err)
  );

  sel_mux_pipe #(.WIDTH(W), .N_IN(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_data(in_data[3*W-1:0]), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(rdy3), .out_data(od3), .out_valid(ov3),
    .out_ready(out_ready), .sel_err(err3), .clr_err(clr_err)
  );

  // Expected selector result: word s of d, or zero when s is out of range.
  function automatic logic [W-1:0] refMux(input int n, input logic [4*W-1:0] d, input int s);
    if (s >= n) return '0;
    return d[s*W +: W];
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    asserts++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    chk("in_ready4", W'(rdy4), W'(q4.size() < 2));
    chk("out_valid4", W'(ov4), W'(q4.size() != 0));
    chk("sel_err4", W'(err4), W'(merr4));
    if (q4.size() != 0) chk("out_data4", od4, q4[0]);
    chk("in_ready3", W'(rdy3), W'(q3.size() < 2));
    chk("out_valid3", W'(ov3), W'(q3.size() != 0));
    chk("sel_err3", W'(err3), W'(merr3));
    if (q3.size() != 0) chk("out_data3", od3, q3[0]);
  endtask

  // One clock: drive inputs, check current outputs, then advance the model.
  task automatic applyStimulus(input logic v, input logic [1:0] s, input logic [4*W-1:0] d,
                               input logic ordy, input logic clr);
    bit acc4, acc3, xf4, xf3;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = ordy;
    clr_err   = clr;
    #1;
    checkOutput();
    acc4 = v && (q4.size() < 2);
    acc3 = v && (q3.size() < 2);
    xf4  = ordy && (q4.size() != 0);
    xf3  = ordy && (q3.size() != 0);
    @(posedge clk);
    merr4 = (merr4 && !clr) || (acc4 && int'(s) >= 4);
    merr3 = (merr3 && !clr) || (acc3 && int'(s) >= 3);
    if (xf4) void'(q4.pop_front());
    if (xf3) void'(q3.pop_front());
    if (acc4) q4.push_back(refMux(4, d, int'(s)));
    if (acc3) q3.push_back(refMux(3, d, int'(s)));
    #1;
  endtask

  function automatic logic [4*W-1:0] randData();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    logic [4*W-1:0] d, held;
    logic [1:0]     hsel;
    bit             holding;
    int             beats, cycles;
    logic           v, r;

    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0;
    out_ready = 1'b0; clr_err = 1'b0;
    merr4 = 0; merr3 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_data4", od4, '0);
    chk("reset_data3", od3, '0);
    checkOutput();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] directed select of word C");
    d = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    applyStimulus(1'b1, 2'd2, d, 1'b1, 1'b0);
    chk("t2_selC4", od4, 32'hCCCC_CCCC);
    chk("t2_selC3", od3, 32'hCCCC_CCCC);
    applyStimulus(1'b0, 2'd0, d, 1'b1, 1'b0);

    $display("[TB] streaming 8 beats");
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 2'(i % 4), randData(), 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 2'd0, '0, 1'b1, 1'b0);

    $display("[TB] back-pressure with 3 offered beats");
    d = randData();
    applyStimulus(1'b1, 2'd0, d, 1'b0, 1'b0);
    d = randData();
    applyStimulus(1'b1, 2'd1, d, 1'b0, 1'b0);
    held = randData();
    applyStimulus(1'b1, 2'd2, held, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd2, held, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd2, held, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'd2, held, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 2'd0, '0, 1'b1, 1'b0);

    $display("[TB] out-of-range select and sticky error");
    d = randData();
    applyStimulus(1'b1, 2'd3, d, 1'b1, 1'b0);
    chk("t5_zero3", od3, '0);
    chk("t5_err3", W'(err3), W'(1'b1));
    applyStimulus(1'b0, 2'd3, d, 1'b1, 1'b1);
    applyStimulus(1'b0, 2'd3, d, 1'b1, 1'b0);
    chk("t5_clr3", W'(err3), W'(1'b0));
    applyStimulus(1'b1, 2'd3, d, 1'b1, 1'b1);
    chk("t5_setwins3", W'(err3), W'(1'b1));
    applyStimulus(1'b0, 2'd0, '0, 1'b1, 1'b0);

    $display("[TB] asynchronous reset with buffer full");
    applyStimulus(1'b1, 2'd1, randData(), 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd3, randData(), 1'b0, 1'b0);
    applyStimulus(1'b0, 2'd0, '0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("t1_valid4", W'(ov4), W'(1'b0));
    chk("t1_ready4", W'(rdy4), W'(1'b1));
    chk("t1_valid3", W'(ov3), W'(1'b0));
    chk("t1_ready3", W'(rdy3), W'(1'b1));
    chk("t1_err3", W'(err3), W'(1'b0));
    chk("t1_data3", od3, '0);
    q4.delete(); q3.delete(); merr4 = 0; merr3 = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] random traffic");
    beats = 0; cycles = 0; holding = 0;
    held = '0; hsel = '0;
    while (beats < 1000 && cycles < 20000) begin
      if (!holding) begin
        held = randData();
        hsel = 2'($urandom_range(0, 3));
        v    = ($urandom_range(0, 99) < 60);
      end else begin
        v = 1'b1;
      end
      r = ($urandom_range(0, 99) < 55);
      if (v && q4.size() < 2) beats++;
      holding = v && (q4.size() >= 2);
      applyStimulus(v, hsel, held, r, ($urandom_range(0, 99) < 5));
      cycles++;
    end
    if (beats < 1000) chk("random_budget", W'(beats), W'(1000));
    repeat (3) applyStimulus(1'b0, 2'd0, '0, 1'b1, 1'b0);
    chk("drained4", W'(q4.size()), '0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/sel_mux_pipe.md
Name: sel_mux_pipe

Overview:
Parametrised N:1 select multiplexer with a registered output and a valid/ready handshake. It is the pipelined successor to the CPU's fixed 2:1 combinational operand/result selectors, and is used at stage boundaries such as operand select and writeback select. A 2-entry skid buffer sustains full throughput with a registered in_ready. Out-of-range selects are detected and reported through a sticky error flag.

Parameters:
WIDTH, 32, data width of each input and of the output
N_IN, 4, number of selectable inputs (legal range 2..16)
SEL_W, $clog2(N_IN), select width; derived, not overridden by the user

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_data  input  N_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH]
in_sel  input  SEL_W  binary select, sampled together with in_data
in_valid  input  1  upstream has a beat
in_ready  output  1  block can accept a beat (registered)
out_data  output  WIDTH  selected data
out_valid  output  1  out_data is valid
out_ready  input  1  downstream accepts the beat
sel_err  output  1  sticky flag: an accepted beat had in_sel >= N_IN
clr_err  input  1  synchronous clear of sel_err

Behaviour:
- One clock domain (clk); rst is asynchronous and active-high.
- Reset values:
  - out_valid=0, out_data=0, in_ready=1, sel_err=0.
  - Both skid entries empty.
- Accept rule: a beat is accepted when in_valid && in_ready.
  - On accept, mux = in_data[in_sel*WIDTH +: WIDTH] if in_sel < N_IN, else all-zero.
  - The mux result, not the raw inputs, is stored.
- Transfer rule: a beat leaves when out_valid && out_ready.
- Latency: the accepted beat appears on out_data/out_valid on the next rising edge if the output register is empty or draining.
- Storage: a main output register plus one skid register (2 entries).
  - States, by occupancy count:
    - EMPTY (0): in_ready=1, out_valid=0.
    - ONE (1): in_ready=1, out_valid=1.
    - FULL (2): in_ready=0, out_valid=1.
  - Transitions:
    - EMPTY + accept -> ONE.
    - ONE + accept, no transfer -> FULL; the new beat goes to the skid register.
    - ONE + accept + transfer -> ONE; the main register loads the new beat.
    - ONE + transfer, no accept -> EMPTY.
    - FULL + transfer -> ONE; the skid beat moves to main. No accept is possible in FULL.
- in_ready is a registered signal (= count != 2 for the next cycle). It has no combinational path from out_ready.
- Ordering: beats leave strictly in acceptance order; no beat is dropped or duplicated.
- out_data holds its value while out_valid && !out_ready (AXI-style stability).
- sel_err:
  - Set on any accepted beat with in_sel >= N_IN.
  - clr_err clears it. If clear and set occur in the same cycle, set wins.
  - Never set by in_sel values present while in_valid=0 or in_ready=0.
- When N_IN is a power of two, out-of-range selects cannot occur and sel_err stays 0.
- Reset mid-operation: all buffered beats are discarded immediately and outputs return to reset values asynchronously.
- in_valid=1 with in_ready=0: upstream must hold its beat. The block ignores the data.

Decomposition:
- Shared package (cpu_pkg):
  - XLEN=32 default width.
  - A select-width function, clog2 with a minimum of 1.
  - Constants for the writeback-select encoding: ALU=0, MEM=1, PC4=2, IMM=3.
- Sub-module skid_buf2 (WIDTH, clk, rst, valid/ready both sides) holds the 2-entry storage and occupancy logic.
- The top level holds the combinational select, the range check and sel_err.

Test Plan:
1. Reset asserted mid-burst with count=2 -> out_valid=0, in_ready=1 and sel_err=0 immediately, without waiting for a clock edge.
2. N_IN=4, in_data={D,C,B,A}, sel=2, out_ready=1 -> next cycle out_data=32'hCCCC_CCCC when C=32'hCCCC_CCCC.
3. Streaming, out_ready=1, 8 beats with sel cycling 0..3 -> 8 outputs in order, 1/cycle throughput, in_ready stays 1.
4. out_ready=0 while 3 beats are offered -> 2 accepted, in_ready=0 from the cycle after the 2nd accept. Then out_ready=1 -> beats emerge in order and the 3rd is accepted only after in_ready returns to 1.
5. N_IN=3, accepted beat with sel=3 -> out_data=0 and sel_err=1. Pulse clr_err -> sel_err=0. clr_err in the same cycle as a new sel=3 accept -> sel_err stays 1.
6. Random valid/ready back-pressure over 1000 beats, compared against a scoreboard queue -> no loss, duplication or reordering, and out_data stable while stalled.
